// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the multi-cycle multiply/divide unit.
// Signed MULT/DIV support is controlled by the MULDIV_SIGNED_EN macro in muldiv_sequencer.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Step counter must hold 0..w
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide, sharing a single
// WIDTH+1-bit adder; divide uses it as a subtractor and keeps the borrow.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             is_div_in,
  input  logic [WIDTH:0]   hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opd_in,
  output logic [WIDTH:0]   hi_next_c,
  output logic [WIDTH-1:0] lo_next_c
);

  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic             cin;
  logic [WIDTH+1:0] sum;
  logic             q_bit;

  // Divide: x - B as x + ~B + 1; top sum bit set means no borrow
  always_comb begin
    x   = hi_in;
    y   = '0;
    cin = 1'b0;
    if (is_div_in) begin
      x   = {hi_in[WIDTH-1:0], lo_in[WIDTH-1]};
      y   = ~{1'b0, opd_in};
      cin = 1'b1;
    end else if (lo_in[0]) begin
      y = {1'b0, opd_in};
    end
    sum   = {1'b0, x} + {1'b0, y} + (WIDTH+2)'(cin);
    q_bit = sum[WIDTH+1];
    if (is_div_in) begin
      hi_next_c = q_bit ? sum[WIDTH:0] : x;
      lo_next_c = {lo_in[WIDTH-2:0], q_bit};
    end else begin
      hi_next_c = {1'b0, sum[WIDTH:1]};
      lo_next_c = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU unit owning HI/LO; one iteration per cycle, result at FIN.
// Define MULDIV_SIGNED_EN to add signed MULT/DIV (magnitude iteration + sign fixup).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             hi_we_in,
  input  logic             lo_we_in,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic             rd_req_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             stall_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CNT_BITS = cnt_width(WIDTH);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]      acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]    acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]    opd_q, opd_d;
  logic                is_div_q, is_div_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                op_div;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      step_hi;
  logic [WIDTH-1:0]    step_lo;
  logic [WIDTH-1:0]    res_hi, res_lo;

  assign accept = start_in & ((state_q == IDLE) | (state_q == FIN));
  assign op_div = (op_in == OP_DIVU) | (op_in == OP_DIV);

`ifdef MULDIV_SIGNED_EN
  logic             sign_a, sign_b;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;

  assign sign_a = ((op_in == OP_MULT) | (op_in == OP_DIV)) & A_in[WIDTH-1];
  assign sign_b = ((op_in == OP_MULT) | (op_in == OP_DIV)) & B_in[WIDTH-1];
  assign a_mag  = sign_a ? -A_in : A_in;
  assign b_mag  = sign_b ? -B_in : B_in;

  // Quotient/product negate on differing signs; remainder follows the dividend
  always_comb begin
    res_hi = acc_hi_q[WIDTH-1:0];
    res_lo = acc_lo_q;
    if (is_div_q) begin
      if (b_zero_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        if (sign_a_q ^ sign_b_q) res_lo = -acc_lo_q;
        if (sign_a_q)            res_hi = -acc_hi_q[WIDTH-1:0];
      end
    end else if (sign_a_q ^ sign_b_q) begin
      {res_hi, res_lo} = -{acc_hi_q[WIDTH-1:0], acc_lo_q};
    end
  end
`else
  assign a_mag  = A_in;
  assign b_mag  = B_in;
  assign res_hi = acc_hi_q[WIDTH-1:0];
  assign res_lo = acc_lo_q;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_in (is_div_q),
    .hi_in     (acc_hi_q),
    .lo_in     (acc_lo_q),
    .opd_in    (opd_q),
    .hi_next_c (step_hi),
    .lo_next_c (step_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CNT_BITS'(WIDTH - 1)) state_d = FIN;
      FIN:     state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy also covers the done cycle so a pending MFHI/MFLO waits for the new value
  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opd_d    = opd_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE) | (state_q == FIN);
`ifdef MULDIV_SIGNED_EN
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    a_raw_d  = a_raw_q;
`endif
    if (!busy_q) begin
      if (hi_we_in) hi_d = wdata_in;
      if (lo_we_in) lo_d = wdata_in;
    end
    if (state_q == RUN) begin
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
      cnt_d    = cnt_q + CNT_BITS'(1);
    end
    if (state_q == FIN) begin
      hi_d   = res_hi;
      lo_d   = res_lo;
      done_d = 1'b1;
    end
    if (accept) begin
      cnt_d    = '0;
      is_div_d = op_div;
      acc_hi_d = '0;
      acc_lo_d = op_div ? a_mag : b_mag;
      opd_d    = op_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
      sign_a_d = sign_a;
      sign_b_d = sign_b;
      b_zero_d = (B_in == '0);
      a_raw_d  = A_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opd_q    <= opd_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef MULDIV_SIGNED_EN
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      a_raw_q  <= a_raw_d;
`endif
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign stall_out = rd_req_in & busy_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic model of HI/LO.
// Honours MULDIV_SIGNED_EN the same way as the design.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_in = 1'b0;
  logic [1:0]   op_in = 2'b00;
  logic [W-1:0] A_in = '0;
  logic [W-1:0] B_in = '0;
  logic         hi_we_in = 1'b0;
  logic         lo_we_in = 1'b0;
  logic [W-1:0] wdata_in = '0;
  logic         rd_req_in = 1'b0;
  logic         busy_out, done_out, stall_out;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (start_in),
    .op_in     (op_in),
    .A_in      (A_in),
    .B_in      (B_in),
    .hi_we_in  (hi_we_in),
    .lo_we_in  (lo_we_in),
    .wdata_in  (wdata_in),
    .rd_req_in (rd_req_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .stall_out (stall_out),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    bit     sgn;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = op[1];
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!op[0]) begin
      if (sgn) return 64'(sa * sb);
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic logic [31:0] rnd_opd();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom % 16);
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation from its start cycle (or from the cycle after a FIN-accept)
  // through its done cycle, checking every cycle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit rd, input bit disturb, input bit wr_start, input bit pre,
                        input bit chain, input logic [1:0] nop, input logic [W-1:0] na,
                        input logic [W-1:0] nb);
    logic [63:0] res;
    res = model(op, a, b);
    if (!pre) begin
      start_in = 1'b1; op_in = op; A_in = a; B_in = b;
      if (wr_start) begin
        hi_we_in = 1'b1; lo_we_in = 1'b1; wdata_in = $urandom;
        m_hi = wdata_in; m_lo = wdata_in;
      end
    end
    @(posedge clk); #1;
    for (int m = (pre ? 1 : 0); m <= int'(W) + 1; m++) begin
      start_in = 1'b0; hi_we_in = 1'b0; lo_we_in = 1'b0; rd_req_in = rd;
      if (disturb && m == 4) begin
        start_in = 1'b1; op_in = 2'($urandom); A_in = $urandom; B_in = $urandom;
        hi_we_in = 1'b1; lo_we_in = 1'b1; wdata_in = $urandom;
      end
      if (chain && m == int'(W)) begin
        start_in = 1'b1; op_in = nop; A_in = na; B_in = nb;
      end
      if (m == int'(W) + 1) {m_hi, m_lo} = res;
      #1;
      check($sformatf("done@%0d", m), 64'(done_out), 64'(m == int'(W) + 1));
      check($sformatf("busy@%0d", m), 64'(busy_out), 64'd1);
      check($sformatf("stall@%0d", m), 64'(stall_out), 64'(rd));
      check($sformatf("hi@%0d", m), 64'(hi_out), 64'(m_hi));
      check($sformatf("lo@%0d", m), 64'(lo_out), 64'(m_lo));
      if (m <= int'(W)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Cycle after done: unit idle, no stall, optional MTHI/MTLO applied
  task automatic idle_cycle(input bit wr);
    logic wh, wl;
    logic [W-1:0] wd;
    @(posedge clk); #1;
    wh = wr & $urandom_range(0, 1) == 1;
    wl = wr & $urandom_range(0, 1) == 1;
    wd = $urandom;
    rd_req_in = 1'b1; hi_we_in = wh; lo_we_in = wl; wdata_in = wd;
    #1;
    check("idle_busy", 64'(busy_out), 64'd0);
    check("idle_done", 64'(done_out), 64'd0);
    check("idle_stall", 64'(stall_out), 64'd0);
    @(posedge clk); #1;
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
    hi_we_in = 1'b0; lo_we_in = 1'b0; rd_req_in = 1'b0;
    check("mt_hi", 64'(hi_out), 64'(m_hi));
    check("mt_lo", 64'(lo_out), 64'(m_lo));
  endtask

  initial begin
    logic [1:0]   op, nop;
    logic [W-1:0] a, b, na, nb;
    bit           pre, chain;
    int           pulses;

    // Reset state
    rd_req_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);
    rst_n = 1'b1; rd_req_in = 1'b0;
    @(posedge clk); #1;

    // Directed cases; the first also fires a stray start and MTLO mid-operation
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 2'b00, '0, '0);
    check("multu_max_hi", 64'(hi_out), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo_out), 64'h0000_0001);
    idle_cycle(0);
    run_op(2'b01, 32'd100, 32'd7, 0, 0, 0, 0, 0, 2'b00, '0, '0);
    check("divu_hi", 64'(hi_out), 64'd2);
    check("divu_lo", 64'(lo_out), 64'd14);
    idle_cycle(0);
    run_op(2'b01, 32'h1234, 32'd0, 1, 0, 0, 0, 0, 2'b00, '0, '0);
    check("div0_hi", 64'(hi_out), 64'h1234);
    check("div0_lo", 64'(lo_out), 64'hFFFF_FFFF);
    idle_cycle(1);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0, 2'b00, '0, '0);
`ifdef MULDIV_SIGNED_EN
    check("div_s_hi", 64'(hi_out), 64'hFFFF_FFFF);
    check("div_s_lo", 64'(lo_out), 64'hFFFF_FFFD);
`else
    check("div_s_hi", 64'(hi_out), 64'd1);
    check("div_s_lo", 64'(lo_out), 64'h7FFF_FFFC);
`endif
    idle_cycle(0);

    // Back-to-back via start in FIN
    run_op(2'b00, 32'd3, 32'd5, 1, 0, 0, 0, 1, 2'b01, 32'd1000, 32'd33);
    check("b2b_first_lo", 64'(lo_out), 64'd15);
    run_op(2'b01, 32'd1000, 32'd33, 1, 0, 0, 1, 0, 2'b00, '0, '0);
    check("b2b_second_hi", 64'(hi_out), 64'd10);
    check("b2b_second_lo", 64'(lo_out), 64'd30);
    idle_cycle(1);

    // MTHI/MTLO together with start in IDLE, later overwritten
    run_op(2'b01, 32'd50, 32'd5, 0, 0, 1, 0, 0, 2'b00, '0, '0);
    idle_cycle(0);

    // Reset in cycle 10 of a MULTU aborts it
    start_in = 1'b1; op_in = 2'b00; A_in = $urandom | 32'h1; B_in = $urandom | 32'h1;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    check("abort_busy", 64'(busy_out), 64'd0);
    check("abort_done", 64'(done_out), 64'd0);
    check("abort_hi", 64'(hi_out), 64'd0);
    check("abort_lo", 64'(lo_out), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_out) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    check("abort_hi_hold", 64'(hi_out), 64'd0);
    run_op(2'b00, 32'd123456, 32'd789, 1, 0, 0, 0, 0, 2'b00, '0, '0);
    idle_cycle(1);

    // Randomized operations, some chained through FIN
    pre = 0; op = '0; a = '0; b = '0;
    for (int i = 0; i < 24; i++) begin
      if (!pre) begin
        op = 2'($urandom); a = rnd_opd(); b = rnd_opd();
      end
      chain = (i < 23) && ($urandom % 3 == 0);
      nop = 2'($urandom); na = rnd_opd(); nb = rnd_opd();
      run_op(op, a, b, $urandom_range(0, 1) == 1, $urandom % 4 == 0,
             (!pre) && ($urandom % 3 == 0), pre, chain, nop, na, nb);
      if (chain) begin
        pre = 1; op = nop; a = na; b = nb;
      end else begin
        pre = 0;
        idle_cycle(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
